// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath (Moore decode of a 4-bit state).
// Optional bne support is enabled by defining MULTICYCLE_CONTROL_BNE_EN.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       Branch,
    output logic       BranchNe,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ZeroExt,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       IllegalOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        IMMWB  = 4'd10,
        JUMP   = 4'd11,
        ANDIEX = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_CONTROL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    state_t state, next_state;
    logic   illegal_q;
    logic   decode_illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Sticky: only reset clears it; execution carries on regardless.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if (decode_illegal) begin
            illegal_q <= 1'b1;
        end
    end

    always_comb begin
        next_state     = FETCH;
        decode_illegal = 1'b0;
        PCWrite        = 1'b0;
        Branch         = 1'b0;
        BranchNe       = 1'b0;
        IorD           = 1'b0;
        MemRead        = 1'b0;
        MemWrite       = 1'b0;
        IRWrite        = 1'b0;
        RegDst         = 1'b0;
        MemtoReg       = 1'b0;
        RegWrite       = 1'b0;
        ALUSrcA        = 1'b0;
        ALUSrcB        = 2'b00;
        ZeroExt        = 1'b0;
        ALUOp          = 2'b00;
        PCSource       = 2'b00;

        case (state)
            FETCH: begin
                MemRead    = 1'b1;
                IRWrite    = 1'b1;
                PCWrite    = 1'b1;
                ALUSrcB    = 2'b01;
                next_state = DECODE;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (Op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXEC;
                    OP_BEQ:       next_state = BRANCH;
`ifdef MULTICYCLE_CONTROL_BNE_EN
                    OP_BNE:       next_state = BRANCH;
`endif
                    OP_ADDI:      next_state = ADDIEX;
                    OP_ANDI:      next_state = ANDIEX;
                    OP_J:         next_state = JUMP;
                    default: begin
                        next_state     = FETCH;
                        decode_illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = (Op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                IorD       = 1'b1;
                MemRead    = 1'b1;
                next_state = MEMWB;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            EXEC: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'b10;
                next_state = ALUWB;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b01;
                PCSource = 2'b01;
`ifdef MULTICYCLE_CONTROL_BNE_EN
                // Op is still held from DECODE, so it selects the branch sense here.
                Branch   = (Op != OP_BNE);
                BranchNe = (Op == OP_BNE);
`else
                Branch   = 1'b1;
`endif
            end
            ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = IMMWB;
            end
            IMMWB: begin
                RegWrite = 1'b1;
            end
            JUMP: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
            end
            ANDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUOp      = 2'b11;
                ZeroExt    = 1'b1;
                next_state = IMMWB;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

    assign PCEn      = PCWrite | (Branch & Zero) | (BranchNe & ~Zero);
    assign IllegalOp = illegal_q;
    assign State     = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: expected state sequences are queued per
// instruction and popped each cycle; outputs checked against the state table.
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] Op;
    logic       Zero;
    logic       PCWrite, Branch, BranchNe, PCEn, IorD, MemRead, MemWrite, IRWrite;
    logic       RegDst, MemtoReg, RegWrite, ALUSrcA, ZeroExt, IllegalOp;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;
    logic [18:0] outs;

    int total = 0;
    int bad   = 0;
    logic [3:0] q[$];
    logic       ill_exp;
    logic       ill_pend;

    multicycle_control dut (
        .clk(clk), .reset(reset), .Op(Op), .Zero(Zero),
        .PCWrite(PCWrite), .Branch(Branch), .BranchNe(BranchNe), .PCEn(PCEn),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ZeroExt(ZeroExt), .ALUOp(ALUOp),
        .PCSource(PCSource), .IllegalOp(IllegalOp), .State(State)
    );

    assign outs = {PCWrite, Branch, BranchNe, PCEn, IorD, MemRead, MemWrite, IRWrite,
                   RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ZeroExt, ALUOp, PCSource};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    function automatic logic [18:0] exp_vec(input logic [3:0] s, input logic [5:0] op,
                                            input logic z);
        logic pcw, br, bne, iord, mr, mw, irw, rd, m2r, rw, sa, ze;
        logic [1:0] sb, aop, pcs;
        {pcw, br, bne, iord, mr, mw, irw, rd, m2r, rw, sa, ze} = '0;
        sb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (s)
            4'd0:  begin pcw = 1; mr = 1; irw = 1; sb = 2'b01; end
            4'd1:  sb = 2'b11;
            4'd2:  begin sa = 1; sb = 2'b10; end
            4'd3:  begin iord = 1; mr = 1; end
            4'd4:  begin m2r = 1; rw = 1; end
            4'd5:  begin iord = 1; mw = 1; end
            4'd6:  begin sa = 1; aop = 2'b10; end
            4'd7:  begin rd = 1; rw = 1; end
            4'd8: begin
                sa = 1; aop = 2'b01; pcs = 2'b01;
`ifdef MULTICYCLE_CONTROL_BNE_EN
                if (op == 6'b000101) bne = 1; else br = 1;
`else
                br = 1;
`endif
            end
            4'd9:  begin sa = 1; sb = 2'b10; end
            4'd10: rw = 1;
            4'd11: begin pcs = 2'b10; pcw = 1; end
            4'd12: begin sa = 1; sb = 2'b10; aop = 2'b11; ze = 1; end
            default: ;
        endcase
        return {pcw, br, bne, pcw | (br & z) | (bne & ~z), iord, mr, mw, irw,
                rd, m2r, rw, sa, sb, ze, aop, pcs};
    endfunction

    task automatic push_seq(input logic [5:0] op);
        ill_pend = 1'b0;
        q.push_back(4'd0);
        q.push_back(4'd1);
        case (op)
            6'b100011: begin q.push_back(4'd2); q.push_back(4'd3); q.push_back(4'd4); end
            6'b101011: begin q.push_back(4'd2); q.push_back(4'd5); end
            6'b000000: begin q.push_back(4'd6); q.push_back(4'd7); end
            6'b000100: q.push_back(4'd8);
`ifdef MULTICYCLE_CONTROL_BNE_EN
            6'b000101: q.push_back(4'd8);
`endif
            6'b001000: begin q.push_back(4'd9); q.push_back(4'd10); end
            6'b001100: begin q.push_back(4'd12); q.push_back(4'd10); end
            6'b000010: q.push_back(4'd11);
            default:   ill_pend = 1'b1;
        endcase
    endtask

    // Entered and left #1 after the edge that begins FETCH; stops early at stop_at.
    task automatic run(input logic [5:0] op, input int stop_at);
        logic [3:0] s;
        Op = op;
        push_seq(op);
        while (q.size() > 0) begin
            s = q.pop_front();
            chk("state", 32'(State), 32'(s));
            chk("illegal", 32'(IllegalOp), 32'(ill_exp));
            for (int z = 0; z < 2; z++) begin
                Zero = z[0];
                #1;
                chk($sformatf("outs_s%0d_z%0d", s, z), 32'(outs), 32'(exp_vec(s, op, z[0])));
            end
            if (s == 4'd1 && ill_pend) ill_exp = 1'b1;
            if (int'(s) == stop_at) begin
                q.delete();
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset   = 1'b1;
        Op      = 6'b000000;
        Zero    = 1'b0;
        ill_exp = 1'b0;
        ill_pend = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(State), 32'd0);
        chk("rst_illegal", 32'(IllegalOp), 32'd0);
        chk("rst_outs", 32'(outs), 32'(exp_vec(4'd0, 6'b0, 1'b0)));
        reset = 1'b0;

        run(6'b100011, -1);   // lw
        run(6'b000000, -1);   // R-type
        run(6'b000100, -1);   // beq, PCEn checked for both Zero values
        run(6'b001100, -1);   // andi
        run(6'b101011, -1);   // sw
        run(6'b001000, -1);   // addi
        run(6'b111111, -1);   // illegal
        run(6'b000010, -1);   // j, flag stays set
        run(6'b000101, -1);   // bne or illegal depending on build

        // Abort a lw in MEMRD with an asynchronous reset between edges.
        run(6'b100011, 3);
        chk("pre_rst_state", 32'(State), 32'd3);
        #1;
        reset = 1'b1;
        #1;
        ill_exp = 1'b0;
        chk("async_state", 32'(State), 32'd0);
        chk("async_illegal", 32'(IllegalOp), 32'd0);
        chk("async_memread", 32'(MemRead), 32'd1);
        chk("async_regwrite", 32'(RegWrite), 32'd0);
        @(posedge clk);
        #1;
        chk("held_state", 32'(State), 32'd0);
        reset = 1'b0;

        run(6'b000000, -1);   // normal after reset
        chk("final_state", 32'(State), 32'd0);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath; it is the producer side of the ALUOp/funct interface.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives every datapath enable and mux select, and drives ALUOp into the ALU control decoder (which turns ALUOp and funct into the 4-bit ALU operation code).
- Sits between the instruction register opcode field and the datapath.

Parameters:
- None. The state encoding is fixed by this spec.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset; state forced to FETCH
- Op  in  6  opcode, IR[31:26]; stable from the cycle after FETCH until the next FETCH
- Zero  in  1  ALU zero flag, combinational from the ALU
- PCWrite  out  1  unconditional PC write
- Branch  out  1  conditional PC write on equal
- BranchNe  out  1  conditional PC write on not-equal
- PCEn  out  1  = PCWrite | (Branch & Zero) | (BranchNe & ~Zero)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- RegDst  out  1  destination register: 0 = rt, 1 = rd
- MemtoReg  out  1  write-back data: 0 = ALUOut, 1 = MDR
- RegWrite  out  1  register file write
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = register A
- ALUSrcB  out  2  ALU B input: 00 = B, 01 = 4, 10 = extended imm, 11 = sign-extended imm<<2
- ZeroExt  out  1  immediate extension: 1 = zero-extend, 0 = sign-extend
- ALUOp  out  2  00 add, 01 subtract, 10 decode funct, 11 AND
- PCSource  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
- IllegalOp  out  1  sticky flag, set on an undecoded opcode
- State  out  4  current state, for debug

Behaviour:
- Output timing:
  - 4-bit state register updates on the rising edge of clk.
  - All outputs except IllegalOp are a combinational decode of the state (Moore); PCEn additionally uses Zero.
  - Any output not listed for a state is 0.
- Reset:
  - While reset is high, the state is FETCH (0), so outputs show FETCH values.
  - IllegalOp resets to 0.
  - Reset asserted mid-instruction aborts it immediately, with no partial writeback.
- States (encoding: outputs -> next state):
  - 0 FETCH: MemRead, IRWrite, PCWrite, ALUSrcB=01, ALUOp=00 -> DECODE
  - 1 DECODE: ALUSrcB=11, ALUOp=00 -> next state by Op:
    - 100011 or 101011 -> MEMADR
    - 000000 -> EXEC
    - 000100 -> BRANCH
    - 001000 -> ADDIEX
    - 001100 -> ANDIEX
    - 000010 -> JUMP
    - any other opcode -> FETCH, and IllegalOp is set on that edge
  - 2 MEMADR: ALUSrcA, ALUSrcB=10, ALUOp=00 -> MEMRD if Op=100011, else MEMWR
  - 3 MEMRD: IorD, MemRead -> MEMWB
  - 4 MEMWB: MemtoReg, RegWrite -> FETCH
  - 5 MEMWR: IorD, MemWrite -> FETCH
  - 6 EXEC: ALUSrcA, ALUSrcB=00, ALUOp=10 -> ALUWB
  - 7 ALUWB: RegDst, RegWrite -> FETCH
  - 8 BRANCH: ALUSrcA, ALUSrcB=00, ALUOp=01, PCSource=01, Branch -> FETCH
  - 9 ADDIEX: ALUSrcA, ALUSrcB=10, ALUOp=00 -> IMMWB
  - 10 IMMWB: RegWrite (RegDst=0, MemtoReg=0) -> FETCH
  - 11 JUMP: PCSource=10, PCWrite -> FETCH
  - 12 ANDIEX: ALUSrcA, ALUSrcB=10, ALUOp=11, ZeroExt -> IMMWB
  - 13-15 (unreachable): all outputs 0 -> FETCH on the next edge
- Latency in cycles, from FETCH through the return to FETCH:
  - lw 5; sw 4; R-type 4; addi/andi 4; beq 3; j 3; illegal 2
- IllegalOp:
  - Once set, it stays set until reset; execution continues normally.
  - Changing Op outside DECODE and MEMADR has no effect on the state.

Optional Feature:
- Macro: MULTICYCLE_CONTROL_BNE_EN
- Defined:
  - DECODE with Op=000101 -> BRANCH.
  - In BRANCH, BranchNe=1 and Branch=0 for this opcode; Op is still valid there, so the decision uses Op.
  - PCEn = ~Zero in that state.
- Undefined:
  - BranchNe is tied to 0.
  - Op=000101 is illegal: it returns to FETCH and sets IllegalOp.

Test Plan:
- reset=1, then release; Op=100011, Zero=0 -> State sequence 0,1,2,3,4,0. In state 4, RegWrite=1 and MemtoReg=1. In state 0, PCEn=1 and IRWrite=1.
- Op=000000 -> States 0,1,6,7,0. State 6 gives ALUOp=10 and ALUSrcB=00. State 7 gives RegDst=1 and RegWrite=1.
- Op=000100 in state 8 -> PCSource=01 and ALUOp=01:
  - Zero=1 -> PCEn=1
  - Zero=0 -> PCEn=0
- Op=001100 -> States 0,1,12,10,0. State 12 gives ALUOp=11 and ZeroExt=1. Then Op=101011 -> States 0,1,2,5, with MemWrite=1 and IorD=1 in state 5.
- Op=111111 -> States 0,1,0 and IllegalOp=1. A following Op=000010 still runs 0,1,11, with PCSource=10 and PCEn=1, and IllegalOp stays 1.
- Assert reset asynchronously (between clock edges) while in state 3 -> State=0 immediately, IllegalOp=0, MemRead=1. With MULTICYCLE_CONTROL_BNE_EN defined, Op=000101 and Zero=0 in state 8 -> PCEn=1.
